// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: one-cycle capture of EX results with stall hold, flush bubbles,
// misaligned-access suppression, a retired-entry counter and EX-side forward/load-hazard decode.
module ex_mem_reg #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_ALUResult,
    input  logic [31:0]        ex_writeData,
    input  logic [2:0]         ex_funct3,
    input  logic [4:0]         ex_rd,
    input  logic               ex_memRead,
    input  logic               ex_memToReg,
    input  logic               ex_memWrite,
    input  logic               ex_regWrite,
    output logic               mem_valid,
    output logic [31:0]        mem_pc,
    output logic [31:0]        ALUResult,
    output logic [31:0]        writeData,
    output logic [2:0]         mem_funct3,
    output logic [4:0]         mem_rd,
    output logic               memRead,
    output logic               memToReg,
    output logic               memWrite,
    output logic               regWrite,
    output logic               misaligned,
    output logic               misaligned_sticky,
    output logic               fwd_valid,
    output logic [4:0]         fwd_rd,
    output logic [31:0]        fwd_data,
    output logic               load_hazard,
    output logic [COUNT_W-1:0] mem_count
);

    logic mem_access;
    logic addr_bad;
    logic mis_next;
    logic ctl_ok;

    assign mem_access = ex_valid & (ex_memRead | ex_memWrite);

    // funct3[1:0] selects access width: byte, half, word, and 11 is an illegal width
    always_comb begin
        addr_bad = 1'b0;
        case (ex_funct3[1:0])
            2'b00:   addr_bad = 1'b0;
            2'b01:   addr_bad = ex_ALUResult[0];
            2'b10:   addr_bad = |ex_ALUResult[1:0];
            default: addr_bad = 1'b1;
        endcase
    end

    assign mis_next = mem_access & addr_bad;
    assign ctl_ok   = ex_valid & ~mis_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid         <= 1'b0;
            mem_pc            <= 32'd0;
            ALUResult         <= 32'd0;
            writeData         <= 32'd0;
            mem_funct3        <= 3'd0;
            mem_rd            <= 5'd0;
            memRead           <= 1'b0;
            memToReg          <= 1'b0;
            memWrite          <= 1'b0;
            regWrite          <= 1'b0;
            misaligned        <= 1'b0;
            misaligned_sticky <= 1'b0;
            mem_count         <= '0;
        end else if (flush) begin
            mem_valid  <= 1'b0;
            mem_pc     <= 32'd0;
            ALUResult  <= 32'd0;
            writeData  <= 32'd0;
            mem_funct3 <= 3'd0;
            mem_rd     <= 5'd0;
            memRead    <= 1'b0;
            memToReg   <= 1'b0;
            memWrite   <= 1'b0;
            regWrite   <= 1'b0;
            misaligned <= 1'b0;
        end else if (!stall) begin
            // A misaligned entry stays valid so the trap reaches MEM, but never touches RAM or rd
            mem_valid         <= ex_valid;
            mem_pc            <= ex_pc;
            ALUResult         <= ex_ALUResult;
            writeData         <= ex_writeData;
            mem_funct3        <= ex_funct3;
            mem_rd            <= ex_rd;
            memRead           <= ctl_ok & ex_memRead;
            memToReg          <= ctl_ok & ex_memToReg;
            memWrite          <= ctl_ok & ex_memWrite;
            regWrite          <= ctl_ok & ex_regWrite;
            misaligned        <= mis_next;
            misaligned_sticky <= misaligned_sticky | mis_next;
            if (ex_valid) begin
                mem_count <= mem_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign fwd_valid   = mem_valid & regWrite & ~memToReg & (mem_rd != 5'd0);
    assign fwd_rd      = mem_rd;
    assign fwd_data    = ALUResult;
    assign load_hazard = mem_valid & memRead & (mem_rd != 5'd0);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg with a scoreboard of expected register images.
module tb_ex_mem_reg;

    localparam int CW = 4;

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [31:0]   alu;
        logic [31:0]   wd;
        logic [2:0]    f3;
        logic [4:0]    rd;
        logic          mr;
        logic          mtr;
        logic          mw;
        logic          rw;
        logic          mis;
        logic          sticky;
        logic [CW-1:0] count;
    } st_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        mr;
        logic        mtr;
        logic        mw;
        logic        rw;
    } in_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, ex_valid;
    logic [31:0]   ex_pc, ex_ALUResult, ex_writeData;
    logic [2:0]    ex_funct3;
    logic [4:0]    ex_rd;
    logic          ex_memRead, ex_memToReg, ex_memWrite, ex_regWrite;
    logic          mem_valid;
    logic [31:0]   mem_pc, ALUResult, writeData;
    logic [2:0]    mem_funct3;
    logic [4:0]    mem_rd;
    logic          memRead, memToReg, memWrite, regWrite;
    logic          misaligned, misaligned_sticky;
    logic          fwd_valid;
    logic [4:0]    fwd_rd;
    logic [31:0]   fwd_data;
    logic          load_hazard;
    logic [CW-1:0] mem_count;

    int  checks   = 0;
    int  failures = 0;
    st_t model_st;
    st_t exp_q[$];

    ex_mem_reg #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_ALUResult(ex_ALUResult), .ex_writeData(ex_writeData),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_memRead(ex_memRead),
        .ex_memToReg(ex_memToReg), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .ALUResult(ALUResult), .writeData(writeData),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd), .memRead(memRead), .memToReg(memToReg),
        .memWrite(memWrite), .regWrite(regWrite), .misaligned(misaligned),
        .misaligned_sticky(misaligned_sticky), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .load_hazard(load_hazard), .mem_count(mem_count)
    );

    always #5 clk = ~clk;

    function automatic st_t observed();
        return '{mem_valid, mem_pc, ALUResult, writeData, mem_funct3, mem_rd, memRead,
                 memToReg, memWrite, regWrite, misaligned, misaligned_sticky, mem_count};
    endfunction

    function automatic logic [38:0] observed_comb();
        return {fwd_valid, fwd_rd, fwd_data, load_hazard};
    endfunction

    // Decode of forward/hazard outputs from an expected register image
    function automatic logic [38:0] exp_comb(input st_t s);
        return {s.valid & s.rw & ~s.mtr & (s.rd != 5'd0), s.rd, s.alu,
                s.valid & s.mr & (s.rd != 5'd0)};
    endfunction

    function automatic st_t next_state(input st_t c, input in_t i);
        st_t n;
        logic bad, mis, ok;
        n = c;
        if (i.flush) begin
            n        = '0;
            n.sticky = c.sticky;
            n.count  = c.count;
        end else if (!i.stall) begin
            unique case (i.f3[1:0])
                2'b00: bad = 1'b0;
                2'b01: bad = i.alu[0];
                2'b10: bad = (i.alu[1:0] != 2'b00);
                default: bad = 1'b1;
            endcase
            mis      = i.valid & (i.mr | i.mw) & bad;
            ok       = i.valid & ~mis;
            n.valid  = i.valid;
            n.pc     = i.pc;
            n.alu    = i.alu;
            n.wd     = i.wd;
            n.f3     = i.f3;
            n.rd     = i.rd;
            n.mr     = ok & i.mr;
            n.mtr    = ok & i.mtr;
            n.mw     = ok & i.mw;
            n.rw     = ok & i.rw;
            n.mis    = mis;
            n.sticky = c.sticky | mis;
            n.count  = c.count + (i.valid ? 4'd1 : 4'd0);
        end
        return n;
    endfunction

    task automatic check_st(input string tag, input st_t o, input st_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s regs observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_comb(input string tag, input logic [38:0] o, input logic [38:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s fwd/hazard observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input in_t i);
        st_t e;
        stall = i.stall; flush = i.flush; ex_valid = i.valid; ex_pc = i.pc;
        ex_ALUResult = i.alu; ex_writeData = i.wd; ex_funct3 = i.f3; ex_rd = i.rd;
        ex_memRead = i.mr; ex_memToReg = i.mtr; ex_memWrite = i.mw; ex_regWrite = i.rw;
        model_st = next_state(model_st, i);
        exp_q.push_back(model_st);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_st(tag, observed(), e);
            check_comb(tag, observed_comb(), exp_comb(e));
        end
    endtask

    // stall, flush, valid, pc, alu, wd, f3, rd, mr, mtr, mw, rw
    function automatic in_t mk(input logic s, input logic f, input logic v, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] f3,
                               input logic [4:0] rd, input logic mr, input logic mtr,
                               input logic mw, input logic rw);
        return '{s, f, v, pc, alu, wd, f3, rd, mr, mtr, mw, rw};
    endfunction

    initial begin
        rst = 1'b1; stall = 0; flush = 0; ex_valid = 0; ex_pc = 0; ex_ALUResult = 0;
        ex_writeData = 0; ex_funct3 = 0; ex_rd = 0; ex_memRead = 0; ex_memToReg = 0;
        ex_memWrite = 0; ex_regWrite = 0;
        model_st = '0;
        @(posedge clk); #1;
        check_st("reset_regs", observed(), '0);
        check_comb("reset_comb", observed_comb(), 39'd0);
        rst = 1'b0;

        step("alu_fwd",   mk(0,0,1,32'h10,32'h1234,32'h0,3'b000,5'd5,0,0,0,1));
        step("load_haz",  mk(0,0,1,32'h14,32'h100,32'h0,3'b010,5'd7,1,1,0,1));
        step("stall1",    mk(1,0,1,32'h18,32'h2222,32'h9,3'b000,5'd3,0,0,0,1));
        step("stall2",    mk(1,0,1,32'h1c,32'h3333,32'hA,3'b010,5'd4,0,0,1,0));
        step("stall3",    mk(1,0,0,32'h20,32'h4444,32'hB,3'b011,5'd9,1,1,1,1));
        step("st_mis",    mk(0,0,1,32'h24,32'h102,32'hDEAD,3'b010,5'd0,0,0,1,0));
        step("half_ok",   mk(0,0,1,32'h28,32'h104,32'h0,3'b001,5'd8,1,1,0,1));
        step("illegal_w", mk(0,0,1,32'h2c,32'h0,32'h0,3'b011,5'd6,1,1,0,1));
        step("half_odd",  mk(0,0,1,32'h30,32'h105,32'h55,3'b001,5'd0,0,0,1,0));
        step("byte_odd",  mk(0,0,1,32'h34,32'h107,32'h0,3'b100,5'd2,1,1,0,1));
        step("flush_stl", mk(1,1,1,32'h38,32'h200,32'h77,3'b010,5'd0,0,0,1,0));
        step("refill",    mk(0,0,1,32'h3c,32'h5678,32'h0,3'b000,5'd1,0,0,0,1));

        // asynchronous reset landing mid-cycle on nonzero state
        #3 rst = 1'b1;
        #1;
        check_st("async_rst", observed(), '0);
        check_comb("async_rst", observed_comb(), 39'd0);
        model_st = '0;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst", mk(0,0,1,32'h40,32'h44,32'h0,3'b000,5'd10,0,0,0,1));
        checks++;
        assert (mem_count === 4'd1) else begin
            failures++;
            $error("FAIL post_rst_count observed=%0d expected=1", mem_count);
        end

        for (int k = 0; k < 15; k++) begin
            step("wrap_fill", mk(0,0,1,32'h100 + 32'(k*4),32'(k),32'h0,3'b000,5'd11,0,0,0,1));
        end
        checks++;
        assert (mem_count === 4'd0) else begin
            failures++;
            $error("FAIL wrap_count observed=%0d expected=0", mem_count);
        end

        step("inval_st",  mk(0,0,0,32'h200,32'h300,32'h99,3'b010,5'd0,0,0,1,0));
        step("inval_mis", mk(0,0,0,32'h204,32'h301,32'h0,3'b010,5'd12,1,1,0,1));

        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_leftover count=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

endmodule
